gpr_writeback_scoreboard: RTL and testbench

// Receiving end of the GPR write-back bus: holds the 32x32 general purpose register file plus a busy/tag

---
 rtl/gpr_writeback_scoreboard.sv | 190 +++++++++++++++++++
 tb/tb_gpr_writeback_scoreboard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_writeback_scoreboard.sv
// gpr_writeback_scoreboard
//
// This is the receiving end of the GPR write-back bus. It holds the 32x32 general
// purpose register file and a busy/tag scoreboard.
//
// - Dispatch claims a destination register. The register goes busy and takes the
//   producer tag.
// - A write-back whose tag matches a busy register commits its data and releases
//   the register.
// - Two registered read ports return either the register value or the pending tag.
//
// Configuration macro: GPR_WB_BYPASS_EN
//   Defined: a read in the same cycle as an accepted write-back to that register
//   forwards wb_result.
//   Undefined: the read returns the pre-write state.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   wb_valid/wb_rs_id/wb_reg_addr/
//   wb_result                         write-back beat (always accepted on the bus)
//   wb_stale                          registered: previous beat was discarded
//   disp_valid/disp_reg_addr/
//   disp_rs_id                        destination claim from dispatch
//   disp_ready                        combinational: claim accepted this cycle
//   flush                             drop all pending claims
//   rd_valid/rd_addr_a/rd_addr_b      read request for both ports
//   rd_resp_valid                     response valid, one cycle after rd_valid
//   rd_data_x/rd_busy_x/rd_tag_x      registered read responses (held until next request)
//   busy_count                        registered number of busy registers
module gpr_writeback_scoreboard #(
    parameter int unsigned RS_ID_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    input  logic [RS_ID_WIDTH-1:0] wb_rs_id,
    input  logic [4:0]             wb_reg_addr,
    input  logic [31:0]            wb_result,
    output logic                   wb_stale,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic [4:0]             disp_reg_addr,
    input  logic [RS_ID_WIDTH-1:0] disp_rs_id,
    input  logic                   flush,
    input  logic                   rd_valid,
    input  logic [4:0]             rd_addr_a,
    input  logic [4:0]             rd_addr_b,
    output logic                   rd_resp_valid,
    output logic [31:0]            rd_data_a,
    output logic [31:0]            rd_data_b,
    output logic                   rd_busy_a,
    output logic                   rd_busy_b,
    output logic [RS_ID_WIDTH-1:0] rd_tag_a,
    output logic [RS_ID_WIDTH-1:0] rd_tag_b,
    output logic [5:0]             busy_count
);

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CNT_W    = 6;

    logic [DATA_W-1:0]      gpr_q [NUM_REGS];
    logic [RS_ID_WIDTH-1:0] tag_q [NUM_REGS];
    logic [NUM_REGS-1:0]    busy_q;

    logic                   claim_c;
    logic                   wb_acc_c;
    logic                   cnt_inc_c;
    logic                   cnt_dec_c;
    logic [DATA_W-1:0]      rd_nxt_data_a_c;
    logic [DATA_W-1:0]      rd_nxt_data_b_c;
    logic                   rd_nxt_busy_a_c;
    logic                   rd_nxt_busy_b_c;
    logic [RS_ID_WIDTH-1:0] rd_nxt_tag_a_c;
    logic [RS_ID_WIDTH-1:0] rd_nxt_tag_b_c;

    assign disp_ready = ~flush & ~rst;

    // Event decode. A write-back is judged against the scoreboard as it stands
    // at the start of the cycle, which includes the flush cycle.
    always_comb begin
        claim_c   = disp_valid & disp_ready;
        wb_acc_c  = wb_valid & busy_q[wb_reg_addr] & (tag_q[wb_reg_addr] == wb_rs_id);
        // A claim on a register that is already busy does not add to the count.
        cnt_inc_c = claim_c & ~busy_q[disp_reg_addr];
        // An accepted write-back that is re-claimed in the same cycle keeps the
        // register busy.
        cnt_dec_c = wb_acc_c & ~(claim_c && (disp_reg_addr == wb_reg_addr));
    end

    // Read port A: value as of the start of the cycle, optionally bypassing a
    // same-cycle write-back.
    always_comb begin
        rd_nxt_data_a_c = gpr_q[rd_addr_a];
        rd_nxt_busy_a_c = busy_q[rd_addr_a];
        rd_nxt_tag_a_c  = tag_q[rd_addr_a];
`ifdef GPR_WB_BYPASS_EN
        if (wb_acc_c && (wb_reg_addr == rd_addr_a)) begin
            rd_nxt_data_a_c = wb_result;
            if (claim_c && (disp_reg_addr == rd_addr_a)) begin
                rd_nxt_busy_a_c = 1'b1;
                rd_nxt_tag_a_c  = disp_rs_id;
            end else begin
                rd_nxt_busy_a_c = 1'b0;
                rd_nxt_tag_a_c  = '0;
            end
        end
`endif
    end

    // Read port B: same behaviour as port A.
    always_comb begin
        rd_nxt_data_b_c = gpr_q[rd_addr_b];
        rd_nxt_busy_b_c = busy_q[rd_addr_b];
        rd_nxt_tag_b_c  = tag_q[rd_addr_b];
`ifdef GPR_WB_BYPASS_EN
        if (wb_acc_c && (wb_reg_addr == rd_addr_b)) begin
            rd_nxt_data_b_c = wb_result;
            if (claim_c && (disp_reg_addr == rd_addr_b)) begin
                rd_nxt_busy_b_c = 1'b1;
                rd_nxt_tag_b_c  = disp_rs_id;
            end else begin
                rd_nxt_busy_b_c = 1'b0;
                rd_nxt_tag_b_c  = '0;
            end
        end
`endif
    end

    // Register file, scoreboard and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_count <= '0;
            wb_stale   <= 1'b0;
        end else begin
            if (wb_acc_c) begin
                gpr_q[wb_reg_addr] <= wb_result;
            end
            if (flush) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    tag_q[i] <= '0;
                end
                busy_q     <= '0;
                busy_count <= '0;
            end else begin
                if (wb_acc_c) begin
                    busy_q[wb_reg_addr] <= 1'b0;
                    tag_q[wb_reg_addr]  <= '0;
                end
                // This comes after the write-back release, so a same-register
                // claim wins the scoreboard.
                if (claim_c) begin
                    busy_q[disp_reg_addr] <= 1'b1;
                    tag_q[disp_reg_addr]  <= disp_rs_id;
                end
                busy_count <= busy_count + CNT_W'(cnt_inc_c) - CNT_W'(cnt_dec_c);
            end
            wb_stale <= wb_valid & ~wb_acc_c;
        end
    end

    // Registered read responses. Data is held until the next request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_resp_valid <= 1'b0;
            rd_data_a     <= '0;
            rd_data_b     <= '0;
            rd_busy_a     <= 1'b0;
            rd_busy_b     <= 1'b0;
            rd_tag_a      <= '0;
            rd_tag_b      <= '0;
        end else begin
            rd_resp_valid <= rd_valid;
            if (rd_valid) begin
                rd_data_a <= rd_nxt_data_a_c;
                rd_data_b <= rd_nxt_data_b_c;
                rd_busy_a <= rd_nxt_busy_a_c;
                rd_busy_b <= rd_nxt_busy_b_c;
                rd_tag_a  <= rd_nxt_tag_a_c;
                rd_tag_b  <= rd_nxt_tag_b_c;
            end
        end
    end

endmodule

// File: tb/tb_gpr_writeback_scoreboard.sv
// tb_gpr_writeback_scoreboard
// This is a directed testbench for gpr_writeback_scoreboard. Each expected value
// is worked out by hand for the stimulus step in front of it.
module tb_gpr_writeback_scoreboard;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rs_id;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_result;
    logic        wb_stale;
    logic        disp_valid;
    logic        disp_ready;
    logic [4:0]  disp_reg_addr;
    logic [4:0]  disp_rs_id;
    logic        flush;
    logic        rd_valid;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        rd_resp_valid;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        rd_busy_a;
    logic        rd_busy_b;
    logic [4:0]  rd_tag_a;
    logic [4:0]  rd_tag_b;
    logic [5:0]  busy_count;

    int unsigned n_total;
    int unsigned n_passed;

    gpr_writeback_scoreboard #(.RS_ID_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rs_id(wb_rs_id), .wb_reg_addr(wb_reg_addr),
        .wb_result(wb_result), .wb_stale(wb_stale),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_reg_addr(disp_reg_addr), .disp_rs_id(disp_rs_id),
        .flush(flush),
        .rd_valid(rd_valid), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_resp_valid(rd_resp_valid),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
        .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
        .busy_count(busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // Advance one clock. Outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic claim(input logic [4:0] addr, input logic [4:0] id);
        disp_valid = 1'b1; disp_reg_addr = addr; disp_rs_id = id;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] addr, input logic [4:0] id, input logic [31:0] data);
        wb_valid = 1'b1; wb_reg_addr = addr; wb_rs_id = id; wb_result = data;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        rd_valid = 1'b1; rd_addr_a = a; rd_addr_b = b;
        tick();
        rd_valid = 1'b0;
    endtask

    initial begin
        n_total = 0; n_passed = 0;
        rst = 1'b1; wb_valid = 1'b0; wb_rs_id = '0; wb_reg_addr = '0; wb_result = '0;
        disp_valid = 1'b0; disp_reg_addr = '0; disp_rs_id = '0; flush = 1'b0;
        rd_valid = 1'b0; rd_addr_a = '0; rd_addr_b = '0;

        // Reset state
        tick(); tick();
        check("rst_disp_ready", 32'(disp_ready), 32'h0);
        check("rst_busy_count", 32'(busy_count), 32'h0);
        check("rst_wb_stale", 32'(wb_stale), 32'h0);
        check("rst_resp_valid", 32'(rd_resp_valid), 32'h0);
        check("rst_rd_data_a", rd_data_a, 32'h0);
        rst = 1'b0; #1;
        check("disp_ready_idle", 32'(disp_ready), 32'h1);

        // Claim r3/tag5, then write it back
        claim(5'd3, 5'd5);
        check("claim_r3_count", 32'(busy_count), 32'd1);
        rd(5'd3, 5'd3);
        check("r3_busy_resp_valid", 32'(rd_resp_valid), 32'h1);
        check("r3_busy", 32'(rd_busy_a), 32'h1);
        check("r3_tag", 32'(rd_tag_b), 32'd5);
        wb(5'd3, 5'd5, 32'hDEADBEEF);
        check("wb_r3_stale", 32'(wb_stale), 32'h0);
        check("wb_r3_count", 32'(busy_count), 32'd0);
        rd(5'd3, 5'd0);
        check("r3_data", rd_data_a, 32'hDEADBEEF);
        check("r3_not_busy", 32'(rd_busy_a), 32'h0);
        check("r3_tag_zero", 32'(rd_tag_a), 32'h0);

        // WAW re-tag: the old-tag write-back goes stale and the new tag commits
        claim(5'd7, 5'd2);
        claim(5'd7, 5'd4);
        check("retag_count", 32'(busy_count), 32'd1);
        wb(5'd7, 5'd2, 32'h11111111);
        check("retag_old_stale", 32'(wb_stale), 32'h1);
        check("retag_old_count", 32'(busy_count), 32'd1);
        rd(5'd7, 5'd7);
        check("retag_stale_clear", 32'(wb_stale), 32'h0);
        check("r7_busy", 32'(rd_busy_a), 32'h1);
        check("r7_tag4", 32'(rd_tag_a), 32'd4);
        check("r7_data_old", rd_data_b, 32'h0);
        wb(5'd7, 5'd4, 32'h22222222);
        check("retag_new_stale", 32'(wb_stale), 32'h0);
        rd(5'd7, 5'd7);
        check("r7_data_new", rd_data_a, 32'h22222222);
        check("r7_released", 32'(rd_busy_b), 32'h0);

        // Flush drops all claims, keeps data, and late write-backs go stale
        claim(5'd1, 5'd1);
        claim(5'd2, 5'd2);
        claim(5'd3, 5'd3);
        check("pre_flush_count", 32'(busy_count), 32'd3);
        flush = 1'b1; #1;
        check("flush_disp_ready", 32'(disp_ready), 32'h0);
        tick();
        flush = 1'b0;
        check("flush_count", 32'(busy_count), 32'd0);
        wb(5'd2, 5'd2, 32'h55555555);
        check("late_wb_stale", 32'(wb_stale), 32'h1);
        rd(5'd2, 5'd3);
        check("r2_unchanged", rd_data_a, 32'h0);
        check("r2_not_busy", 32'(rd_busy_a), 32'h0);
        check("r3_kept", rd_data_b, 32'hDEADBEEF);
        check("r3_tag_flushed", 32'(rd_tag_b), 32'h0);

        // Same-cycle write-back and re-claim of r9
        claim(5'd9, 5'd1);
        wb_valid = 1'b1; wb_reg_addr = 5'd9; wb_rs_id = 5'd1; wb_result = 32'hA5A5A5A5;
        disp_valid = 1'b1; disp_reg_addr = 5'd9; disp_rs_id = 5'd6;
        tick();
        wb_valid = 1'b0; disp_valid = 1'b0;
        check("r9_same_stale", 32'(wb_stale), 32'h0);
        check("r9_same_count", 32'(busy_count), 32'd1);
        rd(5'd9, 5'd9);
        check("r9_data", rd_data_a, 32'hA5A5A5A5);
        check("r9_busy", 32'(rd_busy_a), 32'h1);
        check("r9_tag6", 32'(rd_tag_b), 32'd6);
        wb(5'd9, 5'd6, 32'h0);
        check("r9_clear_count", 32'(busy_count), 32'd0);

        // Write-back to r10 and a claim of r11 in the same cycle
        claim(5'd10, 5'd8);
        wb_valid = 1'b1; wb_reg_addr = 5'd10; wb_rs_id = 5'd8; wb_result = 32'hCAFEF00D;
        disp_valid = 1'b1; disp_reg_addr = 5'd11; disp_rs_id = 5'd9;
        tick();
        wb_valid = 1'b0; disp_valid = 1'b0;
        check("diff_reg_count", 32'(busy_count), 32'd1);
        rd(5'd10, 5'd11);
        check("r10_data", rd_data_a, 32'hCAFEF00D);
        check("r11_tag", 32'(rd_tag_b), 32'd9);
        wb(5'd11, 5'd9, 32'h0);

        // Read r4 in the same cycle as its accepted write-back
        claim(5'd4, 5'd3);
        wb_valid = 1'b1; wb_reg_addr = 5'd4; wb_rs_id = 5'd3; wb_result = 32'h12345678;
        rd_valid = 1'b1; rd_addr_a = 5'd4; rd_addr_b = 5'd4;
        tick();
        wb_valid = 1'b0; rd_valid = 1'b0;
`ifdef GPR_WB_BYPASS_EN
        check("bypass_data", rd_data_a, 32'h12345678);
        check("bypass_busy", 32'(rd_busy_b), 32'h0);
        check("bypass_tag", 32'(rd_tag_a), 32'h0);
`else
        check("nobypass_data", rd_data_a, 32'h0);
        check("nobypass_busy", 32'(rd_busy_b), 32'h1);
        check("nobypass_tag", 32'(rd_tag_a), 32'd3);
`endif
        check("r4_count", 32'(busy_count), 32'd0);

        // Claim all 32 registers, then write them all back in order
        for (int i = 0; i < 32; i++) claim(5'(i), 5'(i));
        check("all_claimed_count", 32'(busy_count), 32'd32);
        rd(5'd0, 5'd31);
        check("all_r0_busy", 32'(rd_busy_a), 32'h1);
        check("all_r31_tag", 32'(rd_tag_b), 32'd31);
        for (int i = 0; i < 16; i++) wb(5'(i), 5'(i), 32'h100 + 32'(i));
        check("half_wb_count", 32'(busy_count), 32'd16);
        for (int i = 16; i < 32; i++) wb(5'(i), 5'(i), 32'h100 + 32'(i));
        check("all_wb_count", 32'(busy_count), 32'd0);
        rd(5'd5, 5'd31);
        check("all_r5_data", rd_data_a, 32'h105);
        check("all_r31_data", rd_data_b, 32'h11F);

        // Reset in the middle of a claim sequence
        for (int i = 0; i < 10; i++) claim(5'(i), 5'(i));
        check("pre_reset_count", 32'(busy_count), 32'd10);
        rd_valid = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd0;
        rst = 1'b1;
        tick();
        rd_valid = 1'b0;
        check("mid_rst_count", 32'(busy_count), 32'h0);
        check("mid_rst_resp_valid", 32'(rd_resp_valid), 32'h0);
        check("mid_rst_data", rd_data_a, 32'h0);
        check("mid_rst_busy", 32'(rd_busy_b), 32'h0);
        rst = 1'b0;
        wb(5'd0, 5'd0, 32'hFFFFFFFF);
        check("post_rst_stale", 32'(wb_stale), 32'h1);
        rd(5'd5, 5'd0);
        check("post_rst_r5", rd_data_a, 32'h0);
        check("post_rst_r0", rd_data_b, 32'h0);
        check("post_rst_count", 32'(busy_count), 32'h0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
